// File: rtl/if_prefetch_if.sv
// Bundle of the fetch-stage signals: redirect input, cache request/response
// and the IF/ID handshake. The prefetch stage takes the master side.
interface if_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              inst_available;
  logic [INST_W-1:0] inst_c;
  logic              inst_valid;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              id_ready;
  logic              if_stall;

  modport master (
    input  redirect_valid, redirect_pc, inst_available, inst_c, id_ready,
    output req_valid, req_addr, inst_valid, inst_out, pc_out, if_stall
  );

  modport slave (
    output redirect_valid, redirect_pc, inst_available, inst_c, id_ready,
    input  req_valid, req_addr, inst_valid, inst_out, pc_out, if_stall
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a prefetch queue. Issues one sequential cache
// request at a time, buffers returned instructions with their PCs, and hands
// the queue head to IF/ID. A redirect flushes the queue and makes any
// in-flight response stale so it is dropped when it arrives.
module if_prefetch #(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input logic           clk,
  input logic           rst,
  if_prefetch_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_fetchPc;
  logic [ADDR_W-1:0] r_reqAddrQ;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_pcMem   [DEPTH];
  logic [INST_W-1:0] r_instMem [DEPTH];

  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_notEmpty;

  assign w_notEmpty = (r_count != '0);

  // Next-state and issue/push decisions; redirect suppresses issue and push.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!bus.redirect_valid && (r_count < DEPTH_CNT)) begin
          w_issue     = 1'b1;
          w_stateNext = WAIT;
        end
      end
      WAIT: begin
        if (bus.inst_available) begin
          w_push      = !bus.redirect_valid;
          w_stateNext = IDLE;
        end else if (bus.redirect_valid) begin
          w_stateNext = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.inst_available) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_pop = w_notEmpty && bus.id_ready && !bus.redirect_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fetch PC, in-flight address, queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc  <= ADDR_W'(RESET_PC);
      r_reqAddrQ <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
    end else if (bus.redirect_valid) begin
      r_fetchPc <= bus.redirect_pc;
      r_rdPtr   <= r_wrPtr;
      r_count   <= '0;
    end else begin
      if (w_issue) begin
        r_reqAddrQ <= r_fetchPc;
        r_fetchPc  <= r_fetchPc + ADDR_W'(4);
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; a slot was reserved at issue so a push never overflows.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_pcMem[r_wrPtr]   <= r_reqAddrQ;
      r_instMem[r_wrPtr] <= bus.inst_c;
    end
  end

  assign bus.req_valid  = (r_state != IDLE);
  assign bus.req_addr   = (r_state != IDLE) ? r_reqAddrQ : r_fetchPc;
  assign bus.inst_valid = w_notEmpty;
  assign bus.inst_out   = w_notEmpty ? r_instMem[r_rdPtr] : '0;
  assign bus.pc_out     = w_notEmpty ? r_pcMem[r_rdPtr] : '0;
  assign bus.if_stall   = !w_notEmpty;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a DEPTH=4 and a DEPTH=2 instance share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_if_prefetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  if_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus0 ();
  if_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus1 ();

  if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(2), .RESET_PC(32'h1000)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int unsigned assertCount = 0;
  int unsigned failCount   = 0;

  // Reference model: per instance a queue of {pc, inst}, the next fetch
  // address, and whether a request is outstanding and whether it is stale.
  int          mDepth   [2] = '{4, 2};
  logic [31:0] mResetPc [2] = '{32'h0, 32'h1000};
  logic [31:0] mFetch   [2];
  logic [31:0] mReqAddr [2];
  bit          mOut     [2];
  bit          mStale   [2];
  logic [63:0] mq0 [$];
  logic [63:0] mq1 [$];

  function automatic int qSize(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [63:0] qHead(int k);
    if (k == 0) return (mq0.size() > 0) ? mq0[0] : 64'd0;
    return (mq1.size() > 0) ? mq1[0] : 64'd0;
  endfunction

  task automatic qPush(int k, logic [63:0] e);
    if (k == 0) mq0.push_back(e); else mq1.push_back(e);
  endtask

  task automatic qPop(int k);
    logic [63:0] d;
    if (k == 0) d = mq0.pop_front(); else d = mq1.pop_front();
  endtask

  task automatic qClear(int k);
    if (k == 0) mq0.delete(); else mq1.delete();
  endtask

  task automatic modelStep(int k, bit r, bit rd, logic [31:0] rpc, bit rdy,
                           bit av, logic [31:0] ic);
    int sz;
    sz = qSize(k);
    if (r) begin
      qClear(k);
      mFetch[k]   = mResetPc[k];
      mReqAddr[k] = 32'd0;
      mOut[k]     = 1'b0;
      mStale[k]   = 1'b0;
    end else if (rd) begin
      qClear(k);
      mFetch[k] = rpc;
      if (mOut[k]) begin
        if (av) begin
          mOut[k]   = 1'b0;
          mStale[k] = 1'b0;
        end else begin
          mStale[k] = 1'b1;
        end
      end
    end else begin
      if (sz > 0 && rdy) qPop(k);
      if (mOut[k]) begin
        if (av) begin
          if (!mStale[k]) qPush(k, {mReqAddr[k], ic});
          mOut[k]   = 1'b0;
          mStale[k] = 1'b0;
        end
      end else if (sz < mDepth[k]) begin
        mReqAddr[k] = mFetch[k];
        mFetch[k]   = mFetch[k] + 32'd4;
        mOut[k]     = 1'b1;
      end
    end
  endtask

  task automatic checkVal(string tag, logic [63:0] obs, logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] head;
      bit          nonEmpty;
      head     = qHead(k);
      nonEmpty = (qSize(k) > 0);
      checkVal($sformatf("req_valid%0d", k),
               64'(k == 0 ? bus0.req_valid : bus1.req_valid), 64'(mOut[k]));
      checkVal($sformatf("req_addr%0d", k),
               64'(k == 0 ? bus0.req_addr : bus1.req_addr),
               64'(mOut[k] ? mReqAddr[k] : mFetch[k]));
      checkVal($sformatf("inst_valid%0d", k),
               64'(k == 0 ? bus0.inst_valid : bus1.inst_valid), 64'(nonEmpty));
      checkVal($sformatf("pc_out%0d", k),
               64'(k == 0 ? bus0.pc_out : bus1.pc_out), 64'(head[63:32]));
      checkVal($sformatf("inst_out%0d", k),
               64'(k == 0 ? bus0.inst_out : bus1.inst_out), 64'(head[31:0]));
      checkVal($sformatf("if_stall%0d", k),
               64'(k == 0 ? bus0.if_stall : bus1.if_stall), 64'(!nonEmpty));
    end
  endtask

  // One clock of stimulus; the cache only answers an instance that has a
  // request outstanding in the model.
  task automatic applyStimulus(bit r, bit rd, logic [31:0] rpc, bit rdy, bit av);
    logic [31:0] ic;
    bit          a0;
    bit          a1;
    ic = $urandom;
    a0 = av && mOut[0];
    a1 = av && mOut[1];
    rst                 = r;
    bus0.redirect_valid = rd;
    bus1.redirect_valid = rd;
    bus0.redirect_pc    = rpc;
    bus1.redirect_pc    = rpc;
    bus0.id_ready       = rdy;
    bus1.id_ready       = rdy;
    bus0.inst_available = a0;
    bus1.inst_available = a1;
    bus0.inst_c         = ic;
    bus1.inst_c         = ic;
    @(posedge clk);
    modelStep(0, r, rd, rpc, rdy, a0, ic);
    modelStep(1, r, rd, rpc, rdy, a1, ic);
    #1;
    checkOutput();
  endtask

  task automatic checkReset();
    checkVal("rst_req_valid0", 64'(bus0.req_valid), 64'd0);
    checkVal("rst_req_addr0", 64'(bus0.req_addr), 64'h0);
    checkVal("rst_req_addr1", 64'(bus1.req_addr), 64'h1000);
    checkVal("rst_inst_valid0", 64'(bus0.inst_valid), 64'd0);
    checkVal("rst_inst_out0", 64'(bus0.inst_out), 64'd0);
    checkVal("rst_pc_out0", 64'(bus0.pc_out), 64'd0);
    checkVal("rst_if_stall0", 64'(bus0.if_stall), 64'd1);
  endtask

  initial begin
    bit found;
    bus0.redirect_valid = 1'b0;  bus1.redirect_valid = 1'b0;
    bus0.redirect_pc    = '0;    bus1.redirect_pc    = '0;
    bus0.inst_available = 1'b0;  bus1.inst_available = 1'b0;
    bus0.inst_c         = '0;    bus1.inst_c         = '0;
    bus0.id_ready       = 1'b0;  bus1.id_ready       = 1'b0;
    $display("[TB] start");

    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkReset();

    // Sequential fetch with a 1-cycle cache; first request is RESET_PC.
    applyStimulus(0, 0, 0, 1, 1);
    checkVal("first_req_valid", 64'(bus0.req_valid), 64'd1);
    checkVal("first_req_addr", 64'(bus0.req_addr), 64'h0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mOut[0] && mReqAddr[0] == 32'h8) begin
        found = 1'b1;
        break;
      end
      applyStimulus(0, 0, 0, 1, 1);
    end
    checkVal("reach_wait_0x8", 64'(found), 64'd1);

    // Redirect while waiting on 0x8; the stale response comes 2 cycles later.
    applyStimulus(0, 1, 32'h100, 1, 0);
    checkVal("redir_flush", 64'(bus0.inst_valid), 64'd0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkVal("redir_idle_addr", 64'(bus0.req_addr), 64'h100);
    applyStimulus(0, 0, 0, 1, 0);
    checkVal("redir_req_valid", 64'(bus0.req_valid), 64'd1);
    checkVal("redir_req_addr", 64'(bus0.req_addr), 64'h100);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 1);

    // Stall IF/ID: queues fill, fetching stops, then drain.
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 1);
    checkVal("full_req_valid0", 64'(bus0.req_valid), 64'd0);
    checkVal("full_inst_valid0", 64'(bus0.inst_valid), 64'd1);
    checkVal("full_req_valid1", 64'(bus1.req_valid), 64'd0);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 1, 1);

    // Redirect coinciding with the cache response: no DISCARD state.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mOut[0]) begin
        found = 1'b1;
        break;
      end
      applyStimulus(0, 0, 0, 1, 0);
    end
    checkVal("reach_wait", 64'(found), 64'd1);
    applyStimulus(0, 1, 32'h200, 1, 1);
    checkVal("samecyc_req_valid", 64'(bus0.req_valid), 64'd0);
    checkVal("samecyc_req_addr", 64'(bus0.req_addr), 64'h200);
    applyStimulus(0, 0, 0, 1, 1);
    checkVal("samecyc_issue", 64'(bus0.req_addr), 64'h200);

    // Reset while waiting with 3 entries queued.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (qSize(0) == 3 && mOut[0]) begin
        found = 1'b1;
        break;
      end
      applyStimulus(0, 0, 0, 0, 1);
    end
    checkVal("reach_three_queued", 64'(found), 64'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkReset();
    applyStimulus(0, 0, 0, 1, 0);
    checkVal("restart_addr", 64'(bus0.req_addr), 64'h0);
    checkVal("restart_valid", 64'(bus0.req_valid), 64'd1);

    // Random traffic: redirects, ID back-pressure, variable cache latency.
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 299) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      if (i == 500) begin
        rd  = 1'b1;
        rpc = 32'hFFFF_FFF8;
      end
      applyStimulus(r, rd, rpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue. It sits between `pc_reg`/branch-resolution logic and the IF/ID register, and issues sequential fetch requests to the instruction cache ahead of demand. Returned instructions are buffered in a `DEPTH`-entry FIFO, and the head entry is presented to IF/ID under a valid/ready handshake. A branch redirect flushes the queue and discards any in-flight cache response.

## Interface

Parameters:
- `ADDR_W`, 32: instruction address width.
- `INST_W`, 32: instruction width.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: branch/jump redirect.
- `redirect_pc` in `ADDR_W`: redirect target.
- `req_valid` out 1: fetch request to cache.
- `req_addr` out `ADDR_W`: fetch address.
- `inst_available` in 1: cache response valid, one-cycle pulse.
- `inst_c` in `INST_W`: cache response data.
- `inst_valid` out 1: queue head valid, i.e. queue not empty.
- `inst_out` out `INST_W`: queue head instruction.
- `pc_out` out `ADDR_W`: queue head PC.
- `id_ready` in 1: IF/ID accepts the head this cycle.
- `if_stall` out 1: equals `!inst_valid`.

## Operation

Registers:
- `fetch_pc`: next address to request.
- `req_addr_q`: address of the in-flight request.
- Queue storage of {pc, inst}, with `rd_ptr`, `wr_ptr` (log2(DEPTH) bits, wrapping) and `count` (log2(DEPTH)+1 bits).
- `state`: IDLE / WAIT / DISCARD.

State machine:
- IDLE: if `count < DEPTH`, issue a request.
  - Set `req_addr_q <= fetch_pc` and `fetch_pc <= fetch_pc + 4` (mod 2^ADDR_W).
  - Go to WAIT.
  - Only one outstanding request ever exists, so a slot is reserved by requiring `count < DEPTH` at issue.
- WAIT: `req_valid = 1`, `req_addr = req_addr_q`, both held stable until `inst_available`.
  - On `inst_available`: push {`req_addr_q`, `inst_c`} and go to IDLE.
- DISCARD: the request is held as in WAIT.
  - On `inst_available`: drop the data (no push) and go to IDLE.
- `req_valid = 0` and `req_addr = fetch_pc` in IDLE.

Queue:
- Push and pop in the same cycle are allowed; `count` is unchanged.
- Pop when `inst_valid && id_ready`.
- Overflow is impossible by construction. Pop while empty is ignored.

Redirect (`redirect_valid = 1`) takes priority over push, pop and issue:
- Flush: `count <= 0`, `rd_ptr <= wr_ptr`.
- `fetch_pc <= redirect_pc`.
- WAIT without `inst_available` this cycle → DISCARD.
- WAIT with `inst_available` this cycle → response dropped, go to IDLE.
- IDLE → stays IDLE with no issue this cycle.
- DISCARD → stays DISCARD.
- The head is not consumed, even if `id_ready`.

Reset:
- `fetch_pc = RESET_PC`, state IDLE, `count = 0`, pointers 0, `req_addr_q = 0`.
- Outputs: `req_valid = 0`, `req_addr = RESET_PC`, `inst_valid = 0`, `inst_out = 0`, `pc_out = 0`, `if_stall = 1`.
- Reset overrides redirect.
- Reset mid-WAIT abandons the request; the cache tolerates `req_valid` dropping.

Output rules:
- `inst_out`/`pc_out` are forced to 0 when the queue is empty.
- `req_addr` is always low-2-bit aligned when `redirect_pc`/`RESET_PC` are aligned. No alignment check is performed.

## Timing

- `req_valid` is a registered state decode: high in the cycle after the IDLE issue decision.
- Cache response at edge t → entry visible on `inst_valid`/`inst_out` at t+1.
- Back-to-back fetch cost is one IDLE cycle plus cache latency, so a 1-cycle cache yields one instruction per 2 cycles.
- `DEPTH` lets fetch run ahead during ID stalls.
- Redirect at edge t:
  - `inst_valid = 0` from t+1.
  - From IDLE, the new request is issued at t+1 with `req_valid` high at t+2 and `req_addr = redirect_pc`.
  - From WAIT/DISCARD, the new request is issued only after the stale response is dropped.
- `if_stall` is combinational from `count`; there is no combinational path from `inst_available`, `redirect_valid` or `id_ready` to any output.

## Test plan

- Reset, `RESET_PC = 0x0`, cache answers 1 cycle after `req_valid`, `id_ready = 1`.
  - → Request addresses 0x0, 0x4, 0x8 in order.
  - → `pc_out` sequence 0x0, 0x4, 0x8 with matching `inst_out`.
  - → `if_stall = 1` until the first push.
- `id_ready = 0` with DEPTH=4.
  - → Exactly 4 entries fill (PCs 0x0–0xC).
  - → `req_valid` stays 0 with `count = 4`.
  - → Raising `id_ready` drains in order; fetch resumes at 0x10.
- Redirect to 0x100 while WAIT on 0x8, response arrives 2 cycles later.
  - → Queue empties next cycle.
  - → Stale 0x8 data is never output.
  - → Next request addr 0x100; first `pc_out` after redirect is 0x100.
- Redirect in the same cycle as `inst_available` for 0x4.
  - → 0x4 is dropped.
  - → No DISCARD state.
  - → Next `req_addr` is the redirect target.
- Full queue with simultaneous pop and push (DEPTH=2, steady `id_ready` toggling).
  - → `count` never exceeds 2.
  - → No lost or duplicated PCs across pointer wrap.
- Assert `rst` mid-WAIT with 3 queued entries.
  - → Next cycle all outputs hold reset values.
  - → Fetch restarts at `RESET_PC`.
